// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// A pending requester is picked circularly after the last one served. Its byte is latched
// and handed to the transmitter with a one-cycle DATA_VALID pulse. The scheduler then
// follows TX_BUSY until the frame ends. If Busy never rises, a timeout aborts the frame.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   SCH_EN         allows new arbitration; an in-flight frame always completes
//   REQ            per-requester request level
//   REQ_DATA       requester i byte on [i*DATA_WIDTH +: DATA_WIDTH]
//   TX_BUSY        transmitter Busy flag
//   GNT            one-hot, one-cycle grant pulse
//   TX_P_DATA      latched byte to transmitter
//   TX_DATA_VALID  one-cycle handshake pulse to transmitter
//   ACTIVE_ID      index of requester being served
//   SCH_BUSY       high whenever a frame is in flight
//   TMO_ERR        one-cycle pulse when the Busy timeout aborts a frame
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TMO_CYCLES = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          SCH_EN,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                          TX_BUSY,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic [ID_WIDTH-1:0]           ACTIVE_ID,
  output logic                          SCH_BUSY,
  output logic                          TMO_ERR
);

  localparam int unsigned CntW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StHandshake,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [CntW-1:0]       cnt_q;

  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  tmo_hit;

  // Circular search starting one past the last granted requester.
  always_comb begin
    scan_idx  = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_WIDTH'(i) == win_id) begin
        win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Abort on the edge where the incremented count would reach TMO_CYCLES-1.
  assign tmo_hit = (32'(cnt_q) + 32'd1) >= (TMO_CYCLES - 32'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      ptr_q         <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q         <= '0;
      GNT           <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      ACTIVE_ID     <= '0;
      SCH_BUSY      <= 1'b0;
      TMO_ERR       <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      GNT           <= '0;
      TX_DATA_VALID <= 1'b0;
      TMO_ERR       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (SCH_EN && win_found) begin
            TX_P_DATA     <= win_data;
            ACTIVE_ID     <= win_id;
            GNT           <= NUM_REQ'(1) << win_id;
            TX_DATA_VALID <= 1'b1;
            ptr_q         <= win_id;
            SCH_BUSY      <= 1'b1;
            state_q       <= StHandshake;
          end
        end
        StHandshake: begin
          cnt_q   <= '0;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          // A Busy rise takes priority over an expiring timeout.
          if (TX_BUSY) begin
            state_q <= StWaitDone;
          end else if (tmo_hit) begin
            TMO_ERR  <= 1'b1;
            SCH_BUSY <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (!TX_BUSY) begin
            SCH_BUSY <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          SCH_BUSY <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. A timeline reference model predicts every
// output after each clock edge: it knows the edge of the last grant and applies the
// timing rules (handshake, Busy window, timeout, one idle cycle) as edge arithmetic.
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned ID_WIDTH   = 2;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned TMO_CYCLES = 4;

  logic                          CLK = 1'b0;
  logic                          RST;
  logic                          SCH_EN;
  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic                          TX_BUSY;
  logic [NUM_REQ-1:0]            GNT;
  logic [DATA_WIDTH-1:0]         TX_P_DATA;
  logic                          TX_DATA_VALID;
  logic [ID_WIDTH-1:0]           ACTIVE_ID;
  logic                          SCH_BUSY;
  logic                          TMO_ERR;

  uart_tx_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .ID_WIDTH  (ID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .TMO_CYCLES(TMO_CYCLES)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SCH_EN       (SCH_EN),
    .REQ          (REQ),
    .REQ_DATA     (REQ_DATA),
    .TX_BUSY      (TX_BUSY),
    .GNT          (GNT),
    .TX_P_DATA    (TX_P_DATA),
    .TX_DATA_VALID(TX_DATA_VALID),
    .ACTIVE_ID    (ACTIVE_ID),
    .SCH_BUSY     (SCH_BUSY),
    .TMO_ERR      (TMO_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester bytes and transmitter plan.
  logic [7:0] bytes [NUM_REQ];
  bit         no_busy;
  int         fixed_d, fixed_len;
  int         busy_start, busy_end;

  // Reference model.
  int         edge_n;
  bit         m_idle;
  int         g_edge;
  bit         got_busy;
  int         m_ptr;
  int         n_grants;
  logic [3:0] exp_gnt;
  logic       exp_dv, exp_err, exp_sbusy;
  logic [7:0] exp_data;
  logic [1:0] exp_id;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int idx;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (p + k) % int'(NUM_REQ);
      if (r[ID_WIDTH'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic plan_busy(input int e);
    if (no_busy || (fixed_len == 0 && $urandom_range(0, 4) == 0)) begin
      busy_start = 0;
      busy_end   = 0;
    end else if (fixed_len > 0) begin
      busy_start = e + 1 + fixed_d;
      busy_end   = busy_start + fixed_len;
    end else begin
      busy_start = e + 1 + int'($urandom_range(1, TMO_CYCLES - 1));
      busy_end   = busy_start + int'($urandom_range(1, 12));
    end
  endtask

  task automatic model_reset();
    m_idle    = 1'b1;
    m_ptr     = NUM_REQ - 1;
    got_busy  = 1'b0;
    exp_gnt   = '0;
    exp_dv    = 1'b0;
    exp_err   = 1'b0;
    exp_sbusy = 1'b0;
    exp_data  = '0;
    exp_id    = '0;
    busy_start = 0;
    busy_end   = 0;
  endtask

  // One clock: drive TX_BUSY/REQ_DATA, predict, clock, compare.
  task automatic cycle();
    int w, k;
    TX_BUSY  = !no_busy && (edge_n + 1 >= busy_start) && (edge_n + 1 < busy_end);
    REQ_DATA = {bytes[3], bytes[2], bytes[1], bytes[0]};
    edge_n++;
    exp_gnt = '0;
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    if (m_idle) begin
      if (SCH_EN && REQ != 0) begin
        w        = rr_pick(REQ, m_ptr);
        m_ptr    = w;
        exp_gnt  = 4'(1) << w;
        exp_dv   = 1'b1;
        exp_data = bytes[w];
        exp_id   = 2'(w);
        m_idle   = 1'b0;
        got_busy = 1'b0;
        g_edge   = edge_n;
        n_grants++;
        plan_busy(edge_n);
      end
    end else begin
      k = edge_n - g_edge;
      if (k >= 2) begin
        if (!got_busy) begin
          if (TX_BUSY) got_busy = 1'b1;
          else if (k >= int'(TMO_CYCLES)) begin
            exp_err = 1'b1;
            m_idle  = 1'b1;
          end
        end else if (!TX_BUSY) begin
          m_idle = 1'b1;
        end
      end
    end
    exp_sbusy = !m_idle;
    @(posedge CLK);
    #1;
    check("gnt", 32'(GNT), 32'(exp_gnt));
    check("data_valid", 32'(TX_DATA_VALID), 32'(exp_dv));
    check("p_data", 32'(TX_P_DATA), 32'(exp_data));
    check("active_id", 32'(ACTIVE_ID), 32'(exp_id));
    check("sch_busy", 32'(SCH_BUSY), 32'(exp_sbusy));
    check("tmo_err", 32'(TMO_ERR), 32'(exp_err));
  endtask

  task automatic run(input int n, input bit drop_on_gnt);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (drop_on_gnt) REQ = REQ & ~exp_gnt;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!m_idle && guard < 60) begin
      cycle();
      REQ = REQ & ~exp_gnt;
      guard++;
    end
    check("idle_reached", 32'(m_idle), 32'd1);
  endtask

  initial begin
    RST        = 1'b0;
    SCH_EN     = 1'b0;
    REQ        = '0;
    REQ_DATA   = '0;
    TX_BUSY    = 1'b0;
    no_busy    = 1'b0;
    fixed_d    = 1;
    fixed_len  = 11;
    edge_n     = 0;
    n_grants   = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = 8'h00;
    model_reset();

    repeat (3) @(posedge CLK);
    #1;
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_dv", 32'(TX_DATA_VALID), 32'd0);
    check("rst_pdata", 32'(TX_P_DATA), 32'd0);
    check("rst_id", 32'(ACTIVE_ID), 32'd0);
    check("rst_sbusy", 32'(SCH_BUSY), 32'd0);
    check("rst_tmo", 32'(TMO_ERR), 32'd0);
    RST = 1'b1;

    // Single request, Busy one cycle after DATA_VALID for 11 cycles.
    SCH_EN   = 1'b1;
    bytes[1] = 8'hA5;
    REQ      = 4'b0010;
    cycle();
    check("first_gnt", 32'(GNT), 32'h2);
    check("first_data", 32'(TX_P_DATA), 32'hA5);
    REQ = '0;
    wait_idle();

    // All requesters held high: fairness and back-to-back spacing.
    fixed_len = 3;
    for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = 8'(8'h10 + i);
    REQ = 4'b1111;
    n_grants = 0;
    for (int i = 0; i < 60 && n_grants < 5; i++) cycle();
    check("rr_grants", 32'(n_grants), 32'd5);
    REQ = '0;
    wait_idle();

    // Grant to 2, then 3 and 0 requested during WAIT_DONE.
    fixed_len = 6;
    REQ = 4'b0100;
    run(4, 1'b1);
    REQ = 4'b1001;
    run(30, 1'b1);
    wait_idle();

    // Transmitter never raises Busy: timeout then immediate re-grant.
    no_busy = 1'b1;
    REQ     = 4'b0001;
    run(12, 1'b0);
    no_busy = 1'b0;
    REQ     = '0;
    wait_idle();

    // Arbitration disabled, then enabled, then disabled mid-frame.
    SCH_EN = 1'b0;
    REQ    = 4'b0100;
    run(20, 1'b0);
    SCH_EN = 1'b1;
    run(4, 1'b0);
    SCH_EN = 1'b0;
    run(20, 1'b0);
    SCH_EN = 1'b1;
    REQ    = '0;
    wait_idle();

    // Randomized traffic.
    fixed_len = 0;
    for (int c = 0; c < 2000; c++) begin
      cycle();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (exp_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) REQ[i] = 1'b0;
          else bytes[i] = 8'($urandom);
        end else if (REQ[i]) begin
          if ($urandom_range(0, 31) == 0) REQ[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bytes[i] = 8'($urandom);
          REQ[i]   = 1'b1;
        end
      end
      if ($urandom_range(0, 15) == 0) SCH_EN = ~SCH_EN;
    end
    SCH_EN = 1'b1;
    REQ    = '0;
    wait_idle();

    // Asynchronous reset during WAIT_DONE, then pointer restarts.
    fixed_d   = 1;
    fixed_len = 10;
    bytes[2]  = 8'h5C;
    REQ       = 4'b0100;
    run(5, 1'b1);
    check("in_wait_done", 32'(SCH_BUSY), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("async_gnt", 32'(GNT), 32'd0);
    check("async_dv", 32'(TX_DATA_VALID), 32'd0);
    check("async_pdata", 32'(TX_P_DATA), 32'd0);
    check("async_id", 32'(ACTIVE_ID), 32'd0);
    check("async_sbusy", 32'(SCH_BUSY), 32'd0);
    check("async_tmo", 32'(TMO_ERR), 32'd0);
    model_reset();
    #1;
    RST      = 1'b1;
    bytes[1] = 8'h3E;
    bytes[3] = 8'hC7;
    REQ      = 4'b1010;
    cycle();
    check("post_rst_gnt", 32'(GNT), 32'h2);
    check("post_rst_id", 32'(ACTIVE_ID), 32'd1);
    REQ = REQ & ~exp_gnt;
    run(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
